// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the load/store stage: op and state encodings, default widths
// and small decode helpers used by the FSM.
package lsu_stage_pkg;

    localparam int LSU_ADDR_W = 10;
    localparam int LSU_DATA_W = 32;
    localparam int LSU_BUS_W  = 32;

    localparam logic [2:0] LSU_LB  = 3'd0;
    localparam logic [2:0] LSU_LBU = 3'd1;
    localparam logic [2:0] LSU_LH  = 3'd2;
    localparam logic [2:0] LSU_LHU = 3'd3;
    localparam logic [2:0] LSU_LW  = 3'd4;
    localparam logic [2:0] LSU_SB  = 3'd5;
    localparam logic [2:0] LSU_SH  = 3'd6;
    localparam logic [2:0] LSU_SW  = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RSP  = 2'd3;

    function automatic logic lsu_is_store(input logic [2:0] op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic mis;
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: mis = off[0];
            LSU_LW, LSU_SW:          mis = |off;
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Big-endian lane steering: extracts and extends the loaded lane, and merges store data
// into the word read from RAM for sub-word writes.
module lsu_lane
    import lsu_stage_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_store
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Offset 0 is the most significant lane.
    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_off[1] ? i_word[15:0] : i_word[31:16];
    end

    always_comb begin
        o_load = i_word;
        case (i_op)
            LSU_LB:  o_load = {{24{w_byte[7]}}, w_byte};
            LSU_LBU: o_load = {24'd0, w_byte};
            LSU_LH:  o_load = {{16{w_half[15]}}, w_half};
            LSU_LHU: o_load = {16'd0, w_half};
            default: o_load = i_word;
        endcase
    end

    always_comb begin
        o_store = i_word;
        case (i_op)
            LSU_SB: begin
                case (i_off)
                    2'd0:    o_store[31:24] = i_wdata[7:0];
                    2'd1:    o_store[23:16] = i_wdata[7:0];
                    2'd2:    o_store[15:8]  = i_wdata[7:0];
                    default: o_store[7:0]   = i_wdata[7:0];
                endcase
            end
            LSU_SH: begin
                if (i_off[1]) begin
                    o_store[15:0] = i_wdata[15:0];
                end else begin
                    o_store[31:16] = i_wdata[15:0];
                end
            end
            LSU_SW:  o_store = i_wdata;
            default: o_store = i_word;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store initiator: turns byte/half/word requests into single-word RAM accesses,
// using read-modify-write for sub-word stores and rejecting misaligned/out-of-range ones.
//
// state | meaning
// IDLE  | ready for a request
// RD    | RAM word read (load result or RMW base)
// WR    | single-cycle RAM write
// RSP   | response held until consumed
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    logic [1:0]        r_state;
    logic [2:0]        r_op;
    logic [1:0]        r_off;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_write;
    logic [DATA_W-1:0] r_mem_din;

    logic              w_err;
    logic [ADDR_W-1:0] w_idx;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_store;

    assign w_err = lsu_misaligned(req_op, req_addr[1:0]) | (|req_addr[31:ADDR_W+2]);
    assign w_idx = req_addr[ADDR_W+1:2];

    // The lane works on the live RAM word during RD; its results are registered on exit.
    lsu_lane u_lane (
        .i_op    (r_op),
        .i_off   (r_off),
        .i_word  (mem_dout),
        .i_wdata (r_wdata),
        .o_load  (w_load),
        .o_store (w_store)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= LSU_LB;
            r_off       <= 2'd0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_write <= 1'b0;
            r_mem_din   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_off   <= req_addr[1:0];
                        r_wdata <= req_wdata;
                        if (w_err) begin
                            r_state     <= ST_RSP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else if (req_op == LSU_SW) begin
                            r_state     <= ST_WR;
                            r_mem_addr  <= w_idx;
                            r_mem_write <= 1'b1;
                            r_mem_din   <= req_wdata;
                        end else begin
                            r_state    <= ST_RD;
                            r_mem_addr <= w_idx;
                        end
                    end
                end
                ST_RD: begin
                    if (lsu_is_store(r_op)) begin
                        r_state     <= ST_WR;
                        r_mem_write <= 1'b1;
                        r_mem_din   <= w_store;
                    end else begin
                        r_state     <= ST_RSP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= w_load;
                    end
                end
                ST_WR: begin
                    r_state     <= ST_RSP;
                    r_mem_write <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_mem_write <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_addr  = r_mem_addr;
    assign mem_write = r_mem_write;
    assign mem_din   = r_mem_din;

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: a byte-addressed big-endian memory model predicts
// responses and RAM writes; a monitor compares them as the DUT presents them.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  mem_addr;
    logic        mem_write;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    lsu_stage #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    // RAM: a preload port used during reset, otherwise written by the DUT
    logic [31:0] ram [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = 10'd0;
    logic [31:0] pre_data = 32'd0;
    assign mem_dout = ram[mem_addr];
    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_write) ram[mem_addr] <= mem_din;
    end

    logic [7:0] refb [0:4095];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          hs;
    } rsp_t;
    typedef struct {
        logic [9:0]  addr;
        logic [31:0] din;
        int          at;
    } wr_t;
    rsp_t rq[$];
    wr_t  wq[$];

    logic mon_en = 1'b1;
    int   stall_token = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {refb[4*w], refb[4*w+1], refb[4*w+2], refb[4*w+3]};
    endfunction

    // Drive one request, wait for acceptance, and record what the model expects of it.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        int sz;
        int w;
        logic err;
        logic [31:0] v;
        rsp_t r;
        wr_t  e;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("req_accept_timeout", req_ready, 1'b1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        sz  = (op == 3'd0 || op == 3'd1 || op == 3'd5) ? 1 :
              (op == 3'd2 || op == 3'd3 || op == 3'd6) ? 2 : 4;
        err = ((addr % 32'(sz)) != 0) || (addr >= 32'd4096);
        v   = 32'd0;
        if (!err && op <= 3'd4) begin
            for (int k = 0; k < sz; k++) v = (v << 8) | 32'(refb[addr + 32'(k)]);
            if (op == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (op == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
        end
        if (!err && op >= 3'd5) begin
            for (int k = 0; k < sz; k++) refb[addr + 32'(k)] = 8'(wdata >> (8 * (sz - 1 - k)));
            w      = int'(addr / 4);
            e.addr = 10'(w);
            e.din  = ref_word(w);
            e.at   = cyc + ((op == 3'd7) ? 1 : 2);
            wq.push_back(e);
        end
        r.rdata = v;
        r.err   = err;
        r.lat   = err ? 1 : ((op == 3'd5 || op == 3'd6) ? 3 : 2);
        r.hs    = cyc;
        rq.push_back(r);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || rsp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (n < 200), 1'b1);
    endtask

    // Monitor: owns rsp_ready; compares writes and responses as they appear.
    logic        in_rsp = 1'b0;
    int          stall_used = 0;
    int          stall_left = 0;
    rsp_t        cur;
    wr_t         we;
    logic [31:0] hold_rdata;
    logic        hold_err;
    logic [9:0]  hold_addr;
    int          lat;
    initial rsp_ready = 1'b0;
    always @(negedge clk) begin
        if (reset || !mon_en) begin
            rsp_ready = 1'b1;
        end else begin
            if (mem_write) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=addr %0d din %h required=no write", mem_addr, mem_din);
                end else begin
                    we = wq.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(we.addr));
                    check("wr_din", mem_din, we.din);
                    check("wr_cycle", cyc, we.at);
                end
            end
            if (rsp_valid) begin
                check("req_ready_busy", req_ready, 1'b0);
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    if (stall_token != stall_used) begin
                        stall_used = stall_token;
                        stall_left = 5;
                    end
                    if (rq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rsp actual=rdata %h required=no response", rsp_rdata);
                    end else begin
                        cur = rq.pop_front();
                        lat = cyc - cur.hs;
                        check("rsp_rdata", rsp_rdata, cur.rdata);
                        check("rsp_err", rsp_err, cur.err);
                        if (cur.err) check("err_latency", (lat == 1 || lat == 2), 1'b1);
                        else         check("latency", lat, cur.lat);
                    end
                    hold_rdata = rsp_rdata;
                    hold_err   = rsp_err;
                    hold_addr  = mem_addr;
                end else begin
                    check("rsp_stable_rdata", rsp_rdata, hold_rdata);
                    check("rsp_stable_err", rsp_err, hold_err);
                    check("stall_mem_addr", 32'(mem_addr), 32'(hold_addr));
                end
                if (stall_left > 0) begin
                    rsp_ready = 1'b0;
                    stall_left--;
                end else begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                if (rsp_ready) in_rsp = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        logic [31:0] old;
        int n;

        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp", {rsp_valid, rsp_err, mem_write}, 3'b000);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", mem_din, 32'd0);

        for (int w = 0; w < 64; w++) begin
            v = (w == 5) ? 32'h1122_3344 : (w == 2) ? 32'h80FF_7F01 :
                (w == 3) ? 32'hAABB_CCDD : $urandom;
            for (int k = 0; k < 4; k++) refb[4*w + k] = 8'(v >> (24 - 8*k));
            pre_we   = 1'b1;
            pre_addr = 10'(w);
            pre_data = v;
            @(negedge clk);
        end
        pre_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        issue(3'd0, 32'h14, 32'd0);
        issue(3'd0, 32'h17, 32'd0);
        issue(3'd2, 32'h08, 32'd0);
        issue(3'd3, 32'h08, 32'd0);
        issue(3'd0, 32'h0A, 32'd0);
        issue(3'd1, 32'h09, 32'd0);
        issue(3'd7, 32'h20, 32'hDEAD_BEEF);
        issue(3'd4, 32'h20, 32'd0);
        issue(3'd5, 32'h0D, 32'h0000_0012);
        issue(3'd6, 32'h0E, 32'h0000_5678);
        issue(3'd4, 32'h0C, 32'd0);
        issue(3'd4, 32'h06, 32'd0);
        issue(3'd6, 32'h03, 32'h1234_5678);
        issue(3'd0, 32'h0000_1000, 32'd0);
        drain();
        stall_token++;
        issue(3'd4, 32'h14, 32'd0);
        drain();

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a = $urandom_range(0, 255);
            if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(12, 31));
            issue(3'($urandom_range(0, 7)), a, $urandom);
        end
        drain();

        n = 0;
        for (int w = 0; w < 64; w++) if (ram[w] !== ref_word(w)) n++;
        check("ram_vs_model", n, 0);
        check("writes_outstanding", wq.size(), 0);

        // Reset in the middle of a read-modify-write must write nothing.
        mon_en = 1'b0;
        old = ram[3];
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'd5;
        req_addr  = 32'h0D;
        req_wdata = 32'h0000_00FF;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rmw_accept", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rmw_in_wr", mem_write, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_mem_write", mem_write, 1'b0);
        check("async_rst_mem_din", mem_din, 32'd0);
        check("async_rst_rsp_valid", rsp_valid, 1'b0);
        check("async_rst_req_ready", req_ready, 1'b1);
        @(posedge clk);
        #1;
        check("rst_ram_unchanged", ram[3], old);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1'b1);
        check("post_rst_no_write", mem_write, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
